// File: rtl/sensor_filter.sv
// Tank-level sensor conditioner: 2-flop synchroniser, debounce, jump rejection.
// Optional jump check / FAULT handling is enabled by `define SENSOR_FILTER_JUMP_CHECK_EN.
module sensor_filter #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] sensor_raw,
  output logic [1:0] level,
  output logic       valid,
  output logic       changed,
  output logic       fault,
  output logic [3:0] fault_count
);

  localparam int unsigned           CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       prime;
  logic             cand_valid;
  logic [1:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  state_t           state;

  // Front end: synchroniser and stability counter.
  // prime marks when sync2 holds a genuine sample; until then the candidate is
  // not loaded, so the first code after reset sees the same latency as any
  // later change.
  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values, exactly like the hardware it describes.
  // NOTE: the asynchronous reset clears every flop here; there is no memory
  // array, so nothing is left uninitialised.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync1      <= 2'b00;
      sync2      <= 2'b00;
      prime      <= 2'b00;
      cand_valid <= 1'b0;
      cand       <= 2'b00;
      cnt        <= '0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
      if (prime[1]) begin
        if (!cand_valid || (sync2 != cand)) begin
          cand       <= sync2;
          cnt        <= '0;
          cand_valid <= 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign stable = cand_valid && (sync2 == cand) && (cnt == CNT_MAX);

`ifdef SENSOR_FILTER_JUMP_CHECK_EN
  logic [1:0] dist;
  logic       fault_q;
  logic [3:0] fault_count_q;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    dist = 2'd0;
    if (cand >= level) dist = cand - level;
    else               dist = level - cand;
  end

  assign fault       = fault_q;
  assign fault_count = fault_count_q;
`else
  assign fault       = 1'b0;
  assign fault_count = 4'd0;
`endif

  // Acceptance FSM; all outputs registered and updated on the same edge.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state         <= S_WAIT;
      level         <= 2'b00;
      valid         <= 1'b0;
      changed       <= 1'b0;
`ifdef SENSOR_FILTER_JUMP_CHECK_EN
      fault_q       <= 1'b0;
      fault_count_q <= 4'd0;
`endif
    end else begin
      changed <= 1'b0;
      case (state)
        S_WAIT: begin
          if (stable) begin
            level   <= cand;
            valid   <= 1'b1;
            changed <= (cand != level);
            state   <= S_TRACK;
          end
        end

        S_TRACK: begin
          if (stable && (cand != level)) begin
`ifdef SENSOR_FILTER_JUMP_CHECK_EN
            if (dist == 2'd1) begin
              level   <= cand;
              changed <= 1'b1;
            end else begin
              fault_q <= 1'b1;
              if (fault_count_q != 4'hF) fault_count_q <= fault_count_q + 4'd1;
              state   <= S_FAULT;
            end
`else
            level   <= cand;
            changed <= 1'b1;
`endif
          end
        end

        S_FAULT: begin
`ifdef SENSOR_FILTER_JUMP_CHECK_EN
          // Leave only on a code adjacent to (or equal to) the held level.
          if (stable && (dist <= 2'd1)) begin
            level   <= cand;
            fault_q <= 1'b0;
            changed <= (dist == 2'd1);
            state   <= S_TRACK;
          end
`else
          state <= S_TRACK;
`endif
        end

        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_filter.sv
// Directed, table-driven bench for sensor_filter (default STABLE_CYCLES = 4).
// Expectations follow SENSOR_FILTER_JUMP_CHECK_EN when it is defined.
module tb_sensor_filter;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] sensor_raw;
  logic [1:0] level;
  logic       valid;
  logic       changed;
  logic       fault;
  logic [3:0] fault_count;

  int tests  = 0;
  int failed = 0;

  sensor_filter #(.STABLE_CYCLES(4)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .sensor_raw (sensor_raw),
    .level      (level),
    .valid      (valid),
    .changed    (changed),
    .fault      (fault),
    .fault_count(fault_count)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic [1:0] raw;
    int         cycles;
    int         exp_level;
    int         exp_valid;
    int         exp_pulses;
    int         exp_fault;
    int         exp_fcount;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic [1:0] raw, input int cyc, input int lvl,
                              input int vld, input int pls, input int flt, input int fc);
    vec_t v;
    v.raw = raw; v.cycles = cyc; v.exp_level = lvl; v.exp_valid = vld;
    v.exp_pulses = pls; v.exp_fault = flt; v.exp_fcount = fc;
    vecs.push_back(v);
  endfunction

  // Called at a negedge: drive raw, run n rising edges, count changed pulses.
  task automatic step(input logic [1:0] raw, input int n, output int pulses);
    pulses = 0;
    sensor_raw = raw;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_2);
      @(negedge clk_2);
      if (changed) pulses++;
    end
  endtask

  task automatic check_outputs(input string tag, input int lvl, input int vld,
                               input int flt, input int fc);
    check({tag, ".level"}, int'(level), lvl);
    check({tag, ".valid"}, int'(valid), vld);
    check({tag, ".fault"}, int'(fault), flt);
    check({tag, ".fault_count"}, int'(fault_count), fc);
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    check_outputs(tag, 0, 0, 0, 0);
    check({tag, ".changed"}, int'(changed), 0);
    @(posedge clk_2);
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int exp_fc;

    // Common prefix: power-up, single steps, pulse width, glitch rejection.
    add(2'b00, 6, 0, 0, 0, 0, 0);
    add(2'b00, 1, 0, 1, 0, 0, 0);
    add(2'b01, 6, 0, 1, 0, 0, 0);
    add(2'b01, 1, 1, 1, 1, 0, 0);
    add(2'b01, 3, 1, 1, 0, 0, 0);
    add(2'b10, 7, 2, 1, 1, 0, 0);
    add(2'b01, 7, 1, 1, 1, 0, 0);
    add(2'b10, 3, 1, 1, 0, 0, 0);
    add(2'b01, 8, 1, 1, 0, 0, 0);
    add(2'b00, 7, 0, 1, 1, 0, 0);
`ifdef SENSOR_FILTER_JUMP_CHECK_EN
    add(2'b11, 7, 0, 1, 0, 1, 1);
    add(2'b11, 5, 0, 1, 0, 1, 1);
    add(2'b01, 7, 1, 1, 1, 0, 1);
    add(2'b11, 7, 1, 1, 0, 1, 2);
    add(2'b01, 7, 1, 1, 0, 0, 2);
`else
    add(2'b11, 7, 3, 1, 1, 0, 0);
    add(2'b00, 7, 0, 1, 1, 0, 0);
    add(2'b10, 7, 2, 1, 1, 0, 0);
    add(2'b01, 7, 1, 1, 1, 0, 0);
    add(2'b01, 3, 1, 1, 0, 0, 0);
`endif

    reset = 1'b1;
    sensor_raw = 2'b00;
    repeat (3) @(posedge clk_2);
    @(negedge clk_2);
    check_outputs("reset", 0, 0, 0, 0);
    check("reset.changed", int'(changed), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      step(vecs[i].raw, vecs[i].cycles, p);
      check_outputs(tag, vecs[i].exp_level, vecs[i].exp_valid,
                    vecs[i].exp_fault, vecs[i].exp_fcount);
      check({tag, ".pulses"}, p, vecs[i].exp_pulses);
    end

    // Reset mid-debounce of 10: nothing pending survives.
    step(2'b10, 4, p);
    async_reset_check("rst_debounce");
    step(2'b10, 6, p);
    check_outputs("post_rst6", 0, 0, 0, 0);
    step(2'b10, 1, p);
    check_outputs("post_rst7", 2, 1, 0, 0);
    check("post_rst7.pulses", p, 1);

`ifdef SENSOR_FILTER_JUMP_CHECK_EN
    // Jump 10 -> 00 enters FAULT, then reset from FAULT.
    step(2'b00, 7, p);
    check_outputs("fault_d2", 2, 1, 1, 1);
    check("fault_d2.pulses", p, 0);
    async_reset_check("rst_fault");
    step(2'b00, 7, p);
    check_outputs("relock", 0, 1, 0, 0);

    // Sixteen FAULT entries: count saturates at 15.
    for (int i = 0; i < 16; i++) begin
      exp_fc = (i + 1 > 15) ? 15 : i + 1;
      step(2'b11, 7, p);
      check($sformatf("sat%0d.fault", i), int'(fault), 1);
      check($sformatf("sat%0d.fault_count", i), int'(fault_count), exp_fc);
      step(2'b01, 7, p);
      check($sformatf("sat%0d.exit", i), int'(fault), 0);
    end
    check("sat.final", int'(fault_count), 15);
`else
    // Two-step jump accepted directly without a fault.
    step(2'b00, 7, p);
    check_outputs("jump_d2", 0, 1, 0, 0);
    check("jump_d2.pulses", p, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sensor_filter.md
# sensor_filter

Conditions the 2-bit tank-level sensor code taken from the board switches before it reaches the 7-segment level decoder (00 blank, 01 "0", 10 "1", 11 "2"). It synchronises the raw code, debounces it, rejects physically impossible level jumps, and presents a stable `level` code plus status flags. It sits directly upstream of the decoder: `level` replaces the raw `SWI[1:0]` as the decoder's `sensor` input.

## Interface
- `STABLE_CYCLES`, 4: consecutive equal synchronised samples required to accept a code; legal range 2..255.
- `clk_2`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sensor_raw`  in  2  raw sensor code (from `SWI[1:0]`), asynchronous to `clk_2`.
- `level`  out  2  accepted level code, to the 7-segment decoder.
- `valid`  out  1  high once the first code has been accepted.
- `changed`  out  1  one-cycle pulse when `level` takes a new value.
- `fault`  out  1  high while in FAULT.
- `fault_count`  out  4  saturating count of FAULT entries (see Configuration).

## Operation
- Reset values: `level`=00, `valid`=0, `changed`=0, `fault`=0, `fault_count`=0. Synchronisers, candidate and counter also reset to 0; state is WAIT.
- `reset` asserted at any time, including mid-debounce or in FAULT, returns everything to reset values immediately. No pending acceptance survives.
- Synchroniser: 2 flops, `sync1`<=`sensor_raw`, `sync2`<=`sync1`.
- Stability tracking, every edge:
  - If `sync2`!=`cand`: `cand`<=`sync2` and `cnt`<=0.
  - Otherwise `cnt` increments and saturates at `STABLE_CYCLES-1`.
  - `cnt` width is ceil(log2(STABLE_CYCLES)).
- "Stable" means `sync2`==`cand` and `cnt`==`STABLE_CYCLES-1`.
- Distance `d` = |`cand`−`level`|, computed as unsigned 2-bit values.
- FSM states and transitions:
  - WAIT: on stable, `level`<=`cand`, `valid`<=1, go to TRACK. No jump check. `changed` pulses only if `cand`!=`level`.
  - TRACK: on stable with `cand`!=`level`:
    - `d`==1: `level`<=`cand`, `changed` pulses.
    - `d`>=2: `level` held, no `changed` pulse, `fault`<=1, `fault_count` increments, go to FAULT.
  - FAULT: on stable with `d`<=1: `level`<=`cand`, `fault`<=0, go to TRACK. `changed` pulses only if `d`==1. On stable with `d`>=2: remain in FAULT.
- Glitches shorter than `STABLE_CYCLES` samples never reach `level`.
- `changed` and the `fault` update occur on the same edge as the corresponding `level` update.

## Timing
- Latency: a `sensor_raw` change present before edge 0 is visible on `level` after edge `STABLE_CYCLES`+2, i.e. on the (`STABLE_CYCLES`+3)th rising edge. With the default of 4, this is after edge 6.
- All outputs are registered. There is no combinational path from input to output.
- `changed` is high for exactly one cycle per accepted change.
- After reset, a constant input yields `valid`=1 after `STABLE_CYCLES`+3 edges.
- A new code arriving mid-count restarts the count. There is no partial credit.

## Configuration
- `SENSOR_FILTER_JUMP_CHECK_EN` defined:
  - Jump rejection, the FAULT state, `fault` and `fault_count` behave as described above.
- `SENSOR_FILTER_JUMP_CHECK_EN` undefined:
  - Every stable code differing from `level` is accepted in TRACK, with a `changed` pulse.
  - FAULT is unreachable. `fault` is tied 0 and `fault_count` is tied 0.

## Test plan
- Reset with `sensor_raw`=00 held → `valid` rises after edge 6, `level`=00, no `changed` pulse.
- In TRACK at `level`=01, set raw=10 → after 7 edges `level`=10 and `changed` is high for exactly one cycle.
- In TRACK at `level`=01, raw 01→10 for 3 cycles then back to 01 → `level` stays 01, no `changed` pulse.
- Macro defined, `level`=00, raw=11 → after 7 edges `fault`=1, `fault_count`=1, `level`=00. Then raw=01 → `level`=01, `fault`=0, `changed` pulses.
- Macro undefined, same 00→11 stimulus → `level`=11, `changed` pulses, `fault` remains 0.
- Assert `reset` for 1 cycle mid-debounce of raw=10 and in FAULT → all outputs return to reset values asynchronously. Sixteen FAULT entries → `fault_count` saturates at 15.
